sysctl_regbank: RTL and testbench



---
 rtl/sysctl_regbank.sv | 150 +++++++++++++++
 tb/tb_sysctl_regbank.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sysctl_regbank.sv
// sysctl_regbank: Wishbone pipelined register bank with byte-lane writes.
// Optional IRQ status/enable words: define SYSCTL_REGBANK_IRQ_EN.
module sysctl_regbank #(
  parameter int unsigned g_num_regs = 16,
  parameter logic [63:0] g_ro_mask  = 64'h0,
  parameter logic [32*g_num_regs-1:0] g_rst_vals = '0
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_n_i,
  input  logic [31:0]             wb_adr_i,
  input  logic [31:0]             wb_dat_i,
  output logic [31:0]             wb_dat_o,
  input  logic [3:0]              wb_sel_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  output logic                    wb_ack_o,
  output logic                    wb_stall_o,
  output logic [32*g_num_regs-1:0] regs_o,
  input  logic [32*g_num_regs-1:0] regs_i,
  output logic [g_num_regs-1:0]   wr_stb_o,
  input  logic [31:0]             irq_src_i,
  output logic                    irq_o
);

`ifdef SYSCTL_REGBANK_IRQ_EN
  localparam int unsigned NW = g_num_regs + 2;
`else
  localparam int unsigned NW = g_num_regs;
`endif
  localparam int unsigned AW = (NW > 1) ? $clog2(NW) : 1;

  logic [AW-1:0]         idx;
  logic                  in_rng;
  logic                  acc;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [31:0]           lane_m;
  logic [31:0]           regs_q [g_num_regs];
  logic [31:0]           dat_d;
  logic [31:0]           dat_q;
  logic                  ack_q;
  logic [g_num_regs-1:0] stb_d;
  logic [g_num_regs-1:0] stb_q;

  assign idx = wb_adr_i[AW+1:2];
  // Upper address bits join the range check so that words past the
  // decoded block never alias onto real registers.
  assign in_rng = ~|wb_adr_i[31:AW+2] && (32'(idx) < NW);
  assign acc    = wb_cyc_i & wb_stb_i;
  assign wr_acc = acc & wb_we_i & in_rng;
  assign rd_acc = acc & ~wb_we_i;
  assign lane_m = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                   {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

`ifdef SYSCTL_REGBANK_IRQ_EN
  logic [31:0] src_q;
  logic [31:0] st_d;
  logic [31:0] st_q;
  logic [31:0] en_q;
  logic [31:0] clr;
  logic        irq_q;

  // Set beats clear when both land on the same bit.
  always_comb begin
    clr = '0;
    if (wr_acc && idx == AW'(g_num_regs))
      clr = wb_dat_i & lane_m;
    st_d = (st_q & ~clr) | (irq_src_i & ~src_q);
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      src_q <= '0;
      st_q  <= '0;
      en_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      src_q <= irq_src_i;
      st_q  <= st_d;
      irq_q <= |(st_q & en_q);
      if (wr_acc && idx == AW'(g_num_regs + 1))
        en_q <= (en_q & ~lane_m) | (wb_dat_i & lane_m);
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    dat_d = '0;
    for (int i = 0; i < g_num_regs; i++) begin
      if (in_rng && idx == AW'(i))
        dat_d = g_ro_mask[i] ? regs_i[32*i +: 32] : regs_q[i];
    end
`ifdef SYSCTL_REGBANK_IRQ_EN
    if (in_rng && idx == AW'(g_num_regs))
      dat_d = st_q;
    if (in_rng && idx == AW'(g_num_regs + 1))
      dat_d = en_q;
`endif
  end

  always_comb begin
    stb_d = '0;
    for (int i = 0; i < g_num_regs; i++)
      stb_d[i] = wr_acc && idx == AW'(i);
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < g_num_regs; i++)
        regs_q[i] <= g_rst_vals[32*i +: 32];
    end else if (wr_acc) begin
      for (int i = 0; i < g_num_regs; i++) begin
        if (!g_ro_mask[i] && idx == AW'(i))
          regs_q[i] <= (regs_q[i] & ~lane_m) | (wb_dat_i & lane_m);
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      stb_q <= '0;
    end else begin
      ack_q <= acc;
      stb_q <= stb_d;
      if (rd_acc)
        dat_q <= dat_d;
    end
  end

  always_comb begin
    for (int i = 0; i < g_num_regs; i++)
      regs_o[32*i +: 32] = regs_q[i];
  end

  assign wb_ack_o   = ack_q & wb_cyc_i;
  assign wb_stall_o = 1'b0;
  assign wb_dat_o   = dat_q;
  assign wr_stb_o   = stb_q;

  logic unused;
  assign unused = ^{wb_adr_i[1:0], regs_i, irq_src_i};

endmodule

// File: tb/tb_sysctl_regbank.sv
// tb_sysctl_regbank: directed stimulus with a queue-based scoreboard.
// Define SYSCTL_REGBANK_IRQ_EN to exercise the IRQ words.
module tb_sysctl_regbank;
  localparam int N = 16;
  localparam logic [32*N-1:0] RST = 512'hA5 << 64;
  localparam logic [63:0] RO = 64'h8;

  logic            clk = 1'b0;
  logic            rst_n_i;
  logic [31:0]     wb_adr_i;
  logic [31:0]     wb_dat_i;
  logic [31:0]     wb_dat_o;
  logic [3:0]      wb_sel_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic            wb_we_i;
  logic            wb_ack_o;
  logic            wb_stall_o;
  logic [32*N-1:0] regs_o;
  logic [32*N-1:0] regs_i;
  logic [N-1:0]    wr_stb_o;
  logic [31:0]     irq_src_i;
  logic            irq_o;

  typedef struct {
    logic         we;
    logic [31:0]  d;
    logic [N-1:0] s;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  sysctl_regbank #(
    .g_num_regs(N),
    .g_ro_mask (RO),
    .g_rst_vals(RST)
  ) dut (
    .clk_sys_i (clk),
    .rst_n_i   (rst_n_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_sel_i  (wb_sel_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_ack_o  (wb_ack_o),
    .wb_stall_o(wb_stall_o),
    .regs_o    (regs_o),
    .regs_i    (regs_i),
    .wr_stb_o  (wr_stb_o),
    .irq_src_i (irq_src_i),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Queue entries are pushed at the accept edge, so any entry seen
  // at the following falling edge must be matched by an ack.
  always @(negedge clk) begin
    if (rst_n_i) begin
      if (wb_stall_o !== 1'b0) begin
        n_cmp++; n_err++;
        $display("FAIL stall: got %b want 0", wb_stall_o);
      end
      if (wb_ack_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_ack: got 1 want 0");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          n_cmp++;
          if ((!e.we && wb_dat_o !== e.d) || wr_stb_o !== e.s) begin
            n_err++;
            $display("FAIL ack_resp: got dat %h stb %h want dat %h stb %h",
                     wb_dat_o, wr_stb_o, e.d, e.s);
          end
        end
      end else if (sb_q.size() > 0) begin
        n_cmp++; n_err++;
        $display("FAIL missing_ack: got 0 want 1");
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic acc(input logic we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [3:0] sel,
                     input logic [31:0] exp_d, input logic [N-1:0] exp_s);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    @(posedge clk);
    sb_q.push_back('{we, exp_d, exp_s});
    #1;
  endtask

  task automatic idle(input int n);
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n_i   = 1'b0;
    wb_adr_i  = '0;
    wb_dat_i  = '0;
    wb_sel_i  = '0;
    wb_cyc_i  = 1'b0;
    wb_stb_i  = 1'b0;
    wb_we_i   = 1'b0;
    irq_src_i = '0;
    regs_i    = '0;
    regs_i[3*32 +: 32] = 32'hDEAD_BEEF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++)
      chk($sformatf("rst_reg%0d", i), regs_o[32*i +: 32],
          (i == 2) ? 32'hA5 : 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_ack", {31'b0, wb_ack_o}, 32'h0);
    chk("rst_stall", {31'b0, wb_stall_o}, 32'h0);
    chk("rst_stb", {16'b0, wr_stb_o}, 32'h0);
    chk("rst_irq", {31'b0, irq_o}, 32'h0);
    @(posedge clk);
    #1 rst_n_i = 1'b1;
    wb_cyc_i = 1'b1;
    idle(1);

    acc(1, 32'h4, 32'h1234_5678, 4'hF, 0, 16'h0002);
    chk("reg1_at_ack", regs_o[63:32], 32'h1234_5678);
    acc(1, 32'h4, 32'hFFFF_FFFF, 4'b0100, 0, 16'h0002);
    idle(1);
    chk("reg1_lane", regs_o[63:32], 32'h12FF_5678);

    acc(1, 32'h0, 32'hCAFE_0001, 4'hF, 0, 16'h0001);
    acc(1, 32'h20, 32'h8888_8888, 4'h3, 0, 16'h0100);
    acc(0, 32'h0, 32'h0, 4'h0, 32'hCAFE_0001, 0);
    acc(0, 32'hC, 32'h0, 4'h0, 32'hDEAD_BEEF, 0);
    acc(0, 32'hA0, 32'h0, 4'h0, 32'h0, 0);
    acc(0, 32'h20, 32'h0, 4'h0, 32'h0000_8888, 0);
    acc(0, 32'h8, 32'h0, 4'h0, 32'hA5, 0);
    idle(2);

    acc(1, 32'hA0, 32'h1234_5678, 4'hF, 0, 0);
    idle(1);
    chk("oor_wr_ignored", regs_o[8*32 +: 32], 32'h0000_8888);

    acc(1, 32'hC, 32'h5555_5555, 4'hF, 0, 16'h0008);
    acc(0, 32'hC, 32'h0, 4'h0, 32'hDEAD_BEEF, 0);
    idle(1);

`ifdef SYSCTL_REGBANK_IRQ_EN
    acc(1, 32'h44, 32'h1, 4'hF, 0, 0);
    idle(1);
    irq_src_i = 32'h1;
    @(posedge clk); #1;
    chk("irq_lag1", {31'b0, irq_o}, 32'h0);
    @(posedge clk); #1;
    chk("irq_lag2", {31'b0, irq_o}, 32'h1);
    acc(0, 32'h40, 32'h0, 4'h0, 32'h1, 0);
    irq_src_i = 32'h0;
    acc(1, 32'h40, 32'h1, 4'hF, 0, 0);
    idle(2);
    chk("irq_w1c", {31'b0, irq_o}, 32'h0);
    acc(0, 32'h40, 32'h0, 4'h0, 32'h0, 0);
    idle(1);
    irq_src_i = 32'h1;
    acc(1, 32'h40, 32'h1, 4'hF, 0, 0);
    acc(0, 32'h40, 32'h0, 4'h0, 32'h1, 0);
    idle(2);
    chk("irq_set_wins", {31'b0, irq_o}, 32'h1);
`else
    acc(1, 32'h44, 32'hFFFF_FFFF, 4'hF, 0, 0);
    acc(0, 32'h44, 32'h0, 4'h0, 32'h0, 0);
    acc(0, 32'h40, 32'h0, 4'h0, 32'h0, 0);
    irq_src_i = 32'hFFFF_FFFF;
    idle(3);
    chk("irq_off", {31'b0, irq_o}, 32'h0);
    chk("irq_wr_alias", regs_o[31:0], 32'hCAFE_0001);
`endif

    wb_stb_i = 1'b1;
    wb_we_i  = 1'b1;
    wb_adr_i = 32'h18;
    wb_dat_i = 32'h0000_0066;
    wb_sel_i = 4'hF;
    @(posedge clk); #1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    @(negedge clk);
    chk("cyc_drop_ack", {31'b0, wb_ack_o}, 32'h0);
    chk("cyc_drop_wr", regs_o[6*32 +: 32], 32'h66);
    @(posedge clk); #1;
    wb_cyc_i = 1'b1;

    wb_stb_i = 1'b1;
    wb_we_i  = 1'b1;
    wb_adr_i = 32'h14;
    wb_dat_i = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    rst_n_i  = 1'b0;
    wb_stb_i = 1'b0;
    #1;
    chk("abort_ack", {31'b0, wb_ack_o}, 32'h0);
    chk("abort_reg5", regs_o[5*32 +: 32], 32'h0);
    chk("abort_reg1", regs_o[63:32], 32'h0);
    chk("abort_reg2", regs_o[95:64], 32'hA5);
    chk("abort_stb", {16'b0, wr_stb_o}, 32'h0);
    @(negedge clk);
    chk("abort_ack_neg", {31'b0, wb_ack_o}, 32'h0);
    @(posedge clk); #1;
    rst_n_i = 1'b1;
    idle(1);
    acc(0, 32'h4, 32'h0, 4'h0, 32'h0, 0);
    idle(2);

    chk("sb_drain", sb_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
